// File: rtl/spi_shift_ctrl.sv
// SPI host shift stage: serialises tx_data onto s_out and assembles rx_data
// from s_in, stepping on the strobes supplied by the SPI clock generator.
//
// Ports:
//   clk_in, rst_n          system clock, synchronous active-low reset
//   go                     start strobe, honoured only when idle
//   len                    bits per transfer (0 or >MAX_CHAR => MAX_CHAR)
//   lsb                    1: bit 0 first, 0: bit len-1 first
//   tx_negedge/rx_negedge  select which strobe drives/samples the line
//   tx_data                transmit word, captured on an accepted go
//   pos_edge/neg_edge      strobes from the clock generator
//   s_in / s_out           MISO / MOSI
//   tip                    transfer in progress
//   last                   no tx bits remain (to generator last_clk)
//   done                   one-cycle completion pulse
//   rx_data                received word
module spi_shift_ctrl #(
   parameter int MAX_CHAR = 32,
   parameter int CNT_W    = 6
) (
   input  logic                clk_in,
   input  logic                rst_n,
   input  logic                go,
   input  logic [CNT_W-1:0]    len,
   input  logic                lsb,
   input  logic                tx_negedge,
   input  logic                rx_negedge,
   input  logic [MAX_CHAR-1:0] tx_data,
   input  logic                pos_edge,
   input  logic                neg_edge,
   input  logic                s_in,
   output logic                s_out,
   output logic                tip,
   output logic                last,
   output logic                done,
   output logic [MAX_CHAR-1:0] rx_data
);

   localparam int IDX_W = $clog2(MAX_CHAR);
   localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_CHAR);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t              state_q;
   logic [MAX_CHAR-1:0] tx_q;
   logic [MAX_CHAR-1:0] rx_q;
   logic [CNT_W-1:0]    len_q;
   logic [CNT_W-1:0]    tx_cnt_q;
   logic [CNT_W-1:0]    rx_cnt_q;
   logic                lsb_q;
   logic                s_out_q;
   logic                tip_q;
   logic                done_q;

   logic [CNT_W-1:0]    len_eff_d;
   logic [IDX_W-1:0]    pre_idx_d;
   logic [IDX_W-1:0]    tx_idx_d;
   logic [IDX_W-1:0]    rx_idx_d;
   logic                tx_edge;
   logic                rx_edge;

   // Counts run from len down to 1; map a count onto the word bit it owns.
   function automatic logic [IDX_W-1:0] bit_idx(
      input logic             lsb_f,
      input logic [CNT_W-1:0] len_f,
      input logic [CNT_W-1:0] cnt_f
   );
      if (lsb_f)
         return IDX_W'(len_f - cnt_f);
      else
         return IDX_W'(cnt_f - ONE);
   endfunction

   assign len_eff_d = (len == '0 || len > MAXC) ? MAXC : len;
   assign pre_idx_d = bit_idx(lsb, len_eff_d, len_eff_d);
   assign tx_idx_d  = bit_idx(lsb_q, len_q, tx_cnt_q);
   assign rx_idx_d  = bit_idx(lsb_q, len_q, rx_cnt_q);

   assign tx_edge = tx_negedge ? neg_edge : pos_edge;
   assign rx_edge = rx_negedge ? neg_edge : pos_edge;

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         tx_q     <= '0;
         rx_q     <= '0;
         len_q    <= '0;
         tx_cnt_q <= '0;
         rx_cnt_q <= '0;
         lsb_q    <= 1'b0;
         s_out_q  <= 1'b0;
         tip_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (go) begin
                  tx_q     <= tx_data;
                  rx_q     <= '0;
                  len_q    <= len_eff_d;
                  lsb_q    <= lsb;
                  rx_cnt_q <= len_eff_d;
                  tip_q    <= 1'b1;
                  state_q  <= SHIFT;
                  // Falling-edge launch needs the first bit on the
                  // line before the first rising edge arrives.
                  if (tx_negedge) begin
                     s_out_q  <= tx_data[pre_idx_d];
                     tx_cnt_q <= len_eff_d - ONE;
                  end else begin
                     tx_cnt_q <= len_eff_d;
                  end
               end
            end
            SHIFT: begin
               if (tx_edge && tx_cnt_q != '0) begin
                  s_out_q  <= tx_q[tx_idx_d];
                  tx_cnt_q <= tx_cnt_q - ONE;
               end
               if (rx_edge && rx_cnt_q != '0) begin
                  rx_q[rx_idx_d] <= s_in;
                  rx_cnt_q       <= rx_cnt_q - ONE;
                  if (rx_cnt_q == ONE) begin
                     tip_q   <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign s_out   = s_out_q;
   assign tip     = tip_q;
   assign done    = done_q;
   assign rx_data = rx_q;
   assign last    = tip_q && (tx_cnt_q == '0);

endmodule
